// File: rtl/debounce_sync.sv
// Synchroniser + glitch filter: d_raw -> SYNC_STAGES flops -> qualification FSM -> clean level and edge strobes.
// Optional abort counter on glitch_cnt when DEBOUNCE_GLITCH_CNT_EN is defined.
//
// state     | meaning
// STABLE_LO | d_clean=0, synchronised input agrees
// PEND_HI   | s=1 seen, counting toward acceptance of a rising change
// STABLE_HI | d_clean=1, synchronised input agrees
// PEND_LO   | s=0 seen, counting toward acceptance of a falling change
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       d_raw,
  output logic       d_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       pending
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("debounce_sync: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

  localparam int             CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX     = CW'(DEBOUNCE_CYCLES);
  localparam state_t         RESET_STATE = RESET_VALUE ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_d, rise_d, fall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{RESET_VALUE}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter is cleared on every exit from a pending state, so it never exceeds CNT_MAX.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    clean_d = d_clean;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = PEND_HI;
          cnt_d   = CW'(1);
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          clean_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = PEND_LO;
          cnt_d   = CW'(1);
        end
      end
      PEND_LO: begin
        if (s) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          clean_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      cnt_q      <= '0;
      d_clean    <= RESET_VALUE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_clean    <= clean_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
    end
  end

  assign pending = (state_q == PEND_HI) || (state_q == PEND_LO);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort;

  assign abort = ((state_q == PEND_HI) && !s) || ((state_q == PEND_LO) && s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          glitch_cnt <= 8'd0;
    else if (abort && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance (a) driven from a vector table, plus a
// DEBOUNCE_CYCLES=1 / RESET_VALUE=1 instance (b); expectations flow through a queue.
module tb_debounce_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n_a = 1'b0, d_raw_a = 1'b0;
  logic reset_n_b = 1'b0, d_raw_b = 1'b1;
  logic clean_a, rise_a, fall_a, pend_a;
  logic clean_b, rise_b, fall_b, pend_b;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gcnt_a, gcnt_b;
`endif

  debounce_sync dut_a (
    .clk(clk), .reset_n(reset_n_a), .d_raw(d_raw_a),
    .d_clean(clean_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .pending(pend_a)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gcnt_a)
`endif
  );

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VALUE(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .d_raw(d_raw_b),
    .d_clean(clean_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .pending(pend_b)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gcnt_b)
`endif
  );

  // exp packs {d_clean, rise_pulse, fall_pulse, pending}
  typedef struct { logic rst; logic d; logic [3:0] exp; string tag; } vec_t;
  typedef struct { logic sel; logic [3:0] exp; string tag; int idx; } exp_t;

  vec_t       tbl[$];
  exp_t       exp_q[$];
  exp_t       e;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         step_no  = 0;
  logic [3:0] rise_seq [9];
  logic [3:0] fall_seq [9];

  function automatic void add(input logic rst, input logic d, input logic [3:0] exp, input string tag);
    tbl.push_back('{rst, d, exp, tag});
  endfunction

  // Low-level glitch sequence: bit i of dbits/pbits is d_raw / expected pending at step i.
  function automatic void add_seq(input int n, input logic [15:0] dbits, input logic [15:0] pbits,
                                  input string tag);
    for (int i = 0; i < n; i++) add(1'b1, dbits[i], {3'b000, pbits[i]}, tag);
  endfunction

  function automatic void check(input string tag, input int idx, input logic [3:0] act,
                                input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s #%0d: got {clean,rise,fall,pend}=%b, expected %b", tag, idx, act, exp);
  endfunction

  task automatic cycle(input logic sel, input logic rst, input logic d, input logic [3:0] exp,
                       input string tag);
    if (sel) begin reset_n_b = rst; d_raw_b = d; end
    else     begin reset_n_a = rst; d_raw_a = d; end
    step_no++;
    exp_q.push_back('{sel, exp, tag, step_no});
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, e.idx, e.sel ? {clean_b, rise_b, fall_b, pend_b}
                                : {clean_a, rise_a, fall_a, pend_a}, e.exp);
    end
  end

  initial begin
    rise_seq = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000, 4'b1000};
    fall_seq = '{4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000, 4'b0000};

    add(1'b0, 1'b1, 4'b0000, "reset_hold");
    add(1'b0, 1'b0, 4'b0000, "reset_hold");
    add(1'b0, 1'b1, 4'b0000, "reset_hold");
    add(1'b0, 1'b1, 4'b0000, "reset_hold");
    add(1'b1, 1'b0, 4'b0000, "release");
    add(1'b1, 1'b0, 4'b0000, "release");
    for (int i = 0; i < 9; i++) add(1'b1, 1'b1, rise_seq[i], "rise_edge7");
    for (int i = 0; i < 9; i++) add(1'b1, 1'b0, fall_seq[i], "fall_edge7");
    add_seq(5, 16'b00001,    16'b00100,    "glitch_1cyc");
    add_seq(7, 16'b0000111,  16'b0011100,  "glitch_3cyc");
    add_seq(8, 16'b00001111, 16'b00111100, "glitch_4cyc");

    @(negedge clk);
    foreach (tbl[i]) cycle(1'b0, tbl[i].rst, tbl[i].d, tbl[i].exp, tbl[i].tag);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // three aborted candidates above
    check("glitch_cnt_a", 0, gcnt_a[3:0], 4'd3);
`endif

    // Reset in the middle of PEND_HI with the counter at 2
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, rise_seq[i], "pend_before_rst");
    #2 reset_n_a = 1'b0;
    #1 check("async_reset_now", 0, {clean_a, rise_a, fall_a, pend_a}, 4'b0000);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt_rst", 0, gcnt_a[3:0], 4'd0);
`endif
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, "rst_in_pend");
    cycle(1'b0, 1'b0, 1'b1, 4'b0000, "rst_in_pend");
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1, rise_seq[i], "requalify");

    // Instance b: one-cycle qualification, reset level high
    cycle(1'b1, 1'b0, 1'b1, 4'b1000, "b_reset");
    cycle(1'b1, 1'b0, 1'b1, 4'b1000, "b_reset");
    cycle(1'b1, 1'b1, 1'b1, 4'b1000, "b_release");
    cycle(1'b1, 1'b1, 1'b1, 4'b1000, "b_release");
    cycle(1'b1, 1'b1, 1'b0, 4'b1000, "b_glitch");
    cycle(1'b1, 1'b1, 1'b1, 4'b1000, "b_glitch");
    cycle(1'b1, 1'b1, 1'b1, 4'b1001, "b_glitch");
    cycle(1'b1, 1'b1, 1'b1, 4'b1000, "b_glitch");
    cycle(1'b1, 1'b1, 1'b1, 4'b1000, "b_glitch");
    cycle(1'b1, 1'b1, 1'b0, 4'b1000, "b_fall_edge4");
    cycle(1'b1, 1'b1, 1'b0, 4'b1000, "b_fall_edge4");
    cycle(1'b1, 1'b1, 1'b0, 4'b1001, "b_fall_edge4");
    cycle(1'b1, 1'b1, 1'b0, 4'b0010, "b_fall_edge4");
    cycle(1'b1, 1'b1, 1'b0, 4'b0000, "b_fall_edge4");
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt_b", 0, gcnt_b[3:0], 4'd1);
`endif

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
